// File: rtl/toggle_event_receiver.sv
// Toggle event receiver: synchronizes a remote toggle line, turns each level change into
// an event, and queues it in a saturating pending counter drained by a valid/ready consumer.
// Latency: SYNC_STAGES+1 clk edges from tog_in change to evt_valid. Backpressure: evt_ready
// low holds events in the pending counter; events arriving at full are dropped and flagged
// sticky in overflow until clr_ovf.
// Optional build macro TOGGLE_RX_ACK_EN adds ack_tog, a toggle returned on every accept.
module toggle_event_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic [TOT_W-1:0] total,
`ifdef TOGGLE_RX_ACK_EN
    output logic             ack_tog,
`endif
    output logic [1:0]       state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PEND = 2'b01;
    localparam logic [1:0] ST_FULL = 2'b10;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       pending_q, pending_d;
    logic [TOT_W-1:0]       total_q, total_d;
    logic                   overflow_q, overflow_d;
    logic [1:0]             state_q, state_d;
    logic                   sync_q;
    logic                   evt;
    logic                   accept;

    assign sync_q    = sync_chain_q[SYNC_STAGES-1];
    assign evt       = sync_q ^ prev_q;
    assign evt_valid = (pending_q != '0);
    assign accept    = evt_valid & evt_ready;

    assign pending   = pending_q;
    assign total     = total_q;
    assign overflow  = overflow_q;
    assign state     = state_q;

    // Next-state for the synchronizer, edge detector, counters and overflow flag
    always_comb begin
        sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], tog_in};
        prev_d       = sync_q;
        pending_d    = pending_q;
        total_d      = total_q;
        // Clear first so that a loss in the same cycle overrides it
        overflow_d   = overflow_q & ~clr_ovf;

        if (accept) begin
            total_d = total_q + TOT_W'(1);
        end

        if (evt && !accept) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_ONE;
            end
        end else if (!evt && accept) begin
            pending_d = pending_q - PEND_ONE;
        end
    end

    // FSM next state; transitions mirror the pending counter updates above
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (evt) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (accept && !evt && (pending_q == PEND_ONE)) begin
                    state_d = ST_IDLE;
                end else if (evt && !accept && (pending_q == PEND_MAX - PEND_ONE)) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (accept && !evt) begin
                    state_d = ST_PEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset treats the remote toggle reference level as 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain_q <= '0;
            prev_q       <= 1'b0;
            pending_q    <= '0;
            total_q      <= '0;
            overflow_q   <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            sync_chain_q <= sync_chain_d;
            prev_q       <= prev_d;
            pending_q    <= pending_d;
            total_q      <= total_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
        end
    end

`ifdef TOGGLE_RX_ACK_EN
    logic ack_tog_q, ack_tog_d;

    assign ack_tog = ack_tog_q;

    // Return toggle flips once per accepted event
    always_comb begin
        ack_tog_d = ack_tog_q ^ accept;
    end

    // Acknowledge toggle register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_tog_q <= 1'b0;
        end else begin
            ack_tog_q <= ack_tog_d;
        end
    end
`endif

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Directed bench for toggle_event_receiver: inputs change on the falling edge,
// outputs are checked on the falling edge after the rising edge that updates them.
// Expected values are hand-computed per scenario.
module tb_toggle_event_receiver;

    logic       clk;
    logic       rst;
    logic       tog_in;
    logic       evt_ready;
    logic       clr_ovf;
    logic       evt_valid;
    logic [3:0] pending;
    logic       overflow;
    logic [7:0] total;
    logic [1:0] state;
`ifdef TOGGLE_RX_ACK_EN
    logic       ack_tog;
`endif

    int checks;
    int errors;

    toggle_event_receiver #(
        .SYNC_STAGES(2),
        .CNT_W(4),
        .TOT_W(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog_in),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .pending   (pending),
        .overflow  (overflow),
        .total     (total),
`ifdef TOGGLE_RX_ACK_EN
        .ack_tog   (ack_tog),
`endif
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tog_in = 1'b0;
        evt_ready = 1'b0;
        clr_ovf = 1'b0;
        cycles(2);
        rst = 1'b0;
    endtask

    // Flip tog_in, then wait long enough for the event to land in pending
    task automatic toggle_and_wait(input int gap);
        tog_in = ~tog_in;
        cycles(gap);
    endtask

    int pulses;
    int vld_cycles;
    logic last_vld;
`ifdef TOGGLE_RX_ACK_EN
    logic ack_before;
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        tog_in = 1'b0;
        evt_ready = 1'b0;
        clr_ovf = 1'b0;

        // Reset state
        cycles(2);
        check_val("rst_valid", evt_valid, 0);
        check_val("rst_pending", pending, 0);
        check_val("rst_state", state, 0);
        check_val("rst_total", total, 0);
        check_val("rst_overflow", overflow, 0);
        rst = 1'b0;

        // Single toggle, no consumer: valid rises after the third edge
        cycles(1);
        tog_in = 1'b1;
        cycles(2);
        check_val("lat_valid_edge2", evt_valid, 0);
        cycles(1);
        check_val("lat_valid_edge3", evt_valid, 1);
        check_val("lat_pending", pending, 1);
        check_val("lat_state", state, 1);
        check_val("lat_total", total, 0);

        // Five toggles four cycles apart with consumer always ready
        do_reset();
        evt_ready = 1'b1;
        pulses = 0;
        vld_cycles = 0;
        last_vld = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tog_in = ~tog_in;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (evt_valid) vld_cycles++;
                if (evt_valid && !last_vld) pulses++;
                last_vld = evt_valid;
            end
        end
        cycles(4);
        check_val("stream_pulses", pulses, 5);
        check_val("stream_vld_cycles", vld_cycles, 5);
        check_val("stream_total", total, 5);
        check_val("stream_pending", pending, 0);
        check_val("stream_overflow", overflow, 0);
        check_val("stream_state", state, 0);

        // Sixteen toggles with no consumer: saturate and flag the loss
        do_reset();
        for (int t = 0; t < 16; t++) toggle_and_wait(3);
        cycles(2);
        check_val("full_pending", pending, 15);
        check_val("full_state", state, 2);
        check_val("full_overflow", overflow, 1);
        clr_ovf = 1'b1;
        cycles(1);
        clr_ovf = 1'b0;
        check_val("clr_overflow", overflow, 0);
        check_val("clr_pending", pending, 15);

        // Loss coinciding with clear: the set must win
        tog_in = ~tog_in;
        cycles(2);
        clr_ovf = 1'b1;
        cycles(1);
        clr_ovf = 1'b0;
        check_val("setwins_overflow", overflow, 1);
        check_val("setwins_pending", pending, 15);

        // Drain one from full
        evt_ready = 1'b1;
        cycles(1);
        evt_ready = 1'b0;
        check_val("drain_pending", pending, 14);
        check_val("drain_state", state, 1);
        check_val("drain_total", total, 1);

        // Event and accept in the same cycle at pending=3
        do_reset();
        for (int t = 0; t < 3; t++) toggle_and_wait(3);
        check_val("p3_pending", pending, 3);
`ifdef TOGGLE_RX_ACK_EN
        ack_before = ack_tog;
`endif
        tog_in = ~tog_in;
        cycles(2);
        evt_ready = 1'b1;
        cycles(1);
        evt_ready = 1'b0;
        check_val("both_pending", pending, 3);
        check_val("both_total", total, 1);
        check_val("both_state", state, 1);
`ifdef TOGGLE_RX_ACK_EN
        check_val("both_ack_tog", ack_tog, {31'd0, ~ack_before});
`endif
        // Accept alone
        evt_ready = 1'b1;
        cycles(1);
        evt_ready = 1'b0;
        check_val("acc_pending", pending, 2);
        check_val("acc_total", total, 2);

        // Mid-stream reset at pending=7, tog_in left high across release
        do_reset();
        for (int t = 0; t < 7; t++) toggle_and_wait(3);
        check_val("p7_pending", pending, 7);
        check_val("p7_tog_level", tog_in, 1);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_valid", evt_valid, 0);
        check_val("arst_pending", pending, 0);
        check_val("arst_state", state, 0);
        check_val("arst_total", total, 0);
        check_val("arst_overflow", overflow, 0);
        cycles(2);
        rst = 1'b0;
        cycles(6);
        check_val("rel_pending", pending, 1);
        check_val("rel_state", state, 1);
        cycles(6);
        check_val("rel_pending_stable", pending, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
